ref_ramp_sequencer: RTL and testbench
=====================================

# ref_ramp_sequencer

Sequences the setpoint fed to the PID controller. It maps the behaviour FSM action code to a target reference and slews the reference toward that target at a fixed rate on a divided control tick. It provides the tick strobe that paces PID updates and handles emergency stop with a latched fault. It sits between the FSM action output and the PID `ref` input, replacing the direct combinational action-to-ref decode.

## Interface
- `SAMPLE_DIV`, 100, clock cycles per control tick; legal range ≥ 2.
- `STEP`, 50, maximum |ref_out| change per tick; legal range 1..16383.
- `WALK_REF`, 1000, signed 16-bit target for action 3'b001.
- `TURN_REF`, -500, signed 16-bit target for action 3'b010.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `action_in`  in  3  FSM action code: 001 WALK, 010 TURN, any other code STOP (target 0).
- `estop`  in  1  emergency stop, level-sensitive.
- `fault_clr`  in  1  fault clear request, level-sensitive.
- `ref_out`  out  16  signed reference to the PID.
- `tick`  out  1  one-cycle control strobe; ref_out is new in this cycle.
- `settled`  out  1  high when state is IDLE or HOLD.
- `state_out`  out  2  IDLE=0, RAMP=1, HOLD=2, FAULT=3.

## Operation
- Divider: `cnt` counts 0..SAMPLE_DIV-1 and wraps to 0. A tick edge is the rising edge where `cnt == SAMPLE_DIV-1`. The divider runs in every state, including FAULT.
- Target: on each tick edge, `target` is loaded from the decode of `action_in`. Changes to `action_in` between tick edges have no effect.
- Slew, applied on a tick edge in RAMP, or on the tick edge leaving IDLE/HOLD:
  - diff = target − ref_out, computed in 17-bit signed arithmetic. No overflow is possible.
  - If |diff| ≤ STEP, ref_out ← target.
  - Otherwise ref_out ← ref_out + STEP·sign(diff).
  - ref_out never overshoots the target.
- State transitions, evaluated on tick edges unless noted:
  - IDLE: ref_out = 0. If the new target ≠ 0, go to RAMP and apply the first step on the same edge.
  - RAMP: step. If ref_out == target after the step: go to HOLD if target ≠ 0, otherwise go to IDLE.
  - HOLD: if the new target ≠ ref_out, go to RAMP and apply the first step on the same edge. If the new target equals ref_out, stay in HOLD.
  - Any state, any edge: `estop`=1 → FAULT, ref_out ← 0, target ← 0. This is independent of tick and takes priority over everything.
  - FAULT: ref_out held at 0. Go to IDLE on the first edge with `fault_clr`=1 and `estop`=0. If `estop` and `fault_clr` are both 1, estop wins and the block stays in FAULT.
- A direct reversal (e.g. +1000 → −500) ramps continuously through 0 without stopping in IDLE.
- `settled` is a decode of the state register; it is not a comparator.

## Timing
- Reset values: `ref_out`=0, `tick`=0, `settled`=1, `state_out`=0, `cnt`=0, `target`=0. All are applied asynchronously on `rst` assertion and held while `rst`=1.
- `tick` is registered. It is set on each tick edge and cleared on the next edge, so it is high exactly one cycle every SAMPLE_DIV cycles.
- First tick: `tick` is high in cycle SAMPLE_DIV after reset release, counting the first post-release cycle as cycle 1.
- ref_out and state_out change only on tick edges, except under estop. A new ref_out value is visible in the same cycle that `tick` is high, so the PID samples on `tick`.
- Estop latency: ref_out reads 0 and state_out reads 3 in the cycle after the first edge that samples `estop`=1.
- Reset mid-ramp: all outputs return to reset values immediately. There is no residual ramp after release.
- Ramp duration from ref a to target b: ceil(|b−a|/STEP) ticks.

## Test plan
- Reset: assert `rst` asynchronously mid-RAMP (ref_out=350) → ref_out=0, state_out=0, tick=0, settled=1 before the next clock edge. After release, the first tick arrives exactly SAMPLE_DIV cycles later.
- WALK ramp (SAMPLE_DIV=4, STEP=50, action 001) → ref_out is 50, 100, …, 1000 on successive ticks. state_out=1 until the 20th tick, then 2 with settled=1. `tick` has 4-cycle spacing.
- Partial final step (STEP=300, action 001) → ref_out is 300, 600, 900, then exactly 1000. No overshoot.
- Reversal from HOLD at 1000, action 010 → ref_out decreases by 50 per tick through 0 to −500 in 30 ticks, then enters HOLD. Then action 000 → ramps to 0 in 10 ticks, then enters IDLE.
- Estop at ref_out=600 → ref_out=0 and state_out=3 on the next edge. With `fault_clr`=1 and `estop`=1: stays in FAULT. Drop estop → IDLE. With action 001 held, the ramp restarts from 50.
- Action glitch: pulse action 001 for 2 cycles strictly between ticks while in IDLE → no ref change, state stays IDLE.

Source files
------------

// File: rtl/ref_ramp_sequencer.sv
// Setpoint sequencer: decodes the FSM action into a target and slews ref_out toward it
// once per divided control tick, with a latched emergency-stop fault.
module ref_ramp_sequencer #(
   parameter int                 SAMPLE_DIV = 100,
   parameter int                 STEP       = 50,
   parameter logic signed [15:0] WALK_REF   = 16'sd1000,
   parameter logic signed [15:0] TURN_REF   = -16'sd500
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         action_in,
   input  logic               estop,
   input  logic               fault_clr,
   output logic signed [15:0] ref_out,
   output logic               tick,
   output logic               settled,
   output logic [1:0]         state_out
);

   localparam int CW = $clog2(SAMPLE_DIV);
   localparam logic signed [16:0] STEP_W = 17'(STEP);
   localparam logic signed [15:0] STEP_N = 16'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic signed [15:0] ref_q;
   logic               tick_q;

   logic               tick_edge;
   logic signed [15:0] tgt_d;
   logic signed [15:0] step_d;
   logic signed [16:0] diff;
   logic signed [16:0] mag;

   assign tick_edge = (cnt_q == CW'(SAMPLE_DIV - 1));

   // The target is the live decode; it only takes effect on tick edges below.
   always_comb begin
      tgt_d = 16'sd0;
      case (action_in)
         3'b001:  tgt_d = WALK_REF;
         3'b010:  tgt_d = TURN_REF;
         default: tgt_d = 16'sd0;
      endcase
      diff = {tgt_d[15], tgt_d} - {ref_q[15], ref_q};
      mag  = diff[16] ? -diff : diff;
      if (mag <= STEP_W) begin
         step_d = tgt_d;
      end else if (diff[16]) begin
         step_d = ref_q - STEP_N;
      end else begin
         step_d = ref_q + STEP_N;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         ref_q   <= 16'sd0;
         state_q <= IDLE;
      end else begin
         cnt_q  <= tick_edge ? '0 : cnt_q + CW'(1);
         tick_q <= tick_edge;
         if (estop) begin
            state_q <= FAULT;
            ref_q   <= 16'sd0;
         end else begin
            case (state_q)
               FAULT: begin
                  if (fault_clr) state_q <= IDLE;
               end
               IDLE: begin
                  if (tick_edge && tgt_d != 16'sd0) begin
                     state_q <= RAMP;
                     ref_q   <= step_d;
                  end
               end
               RAMP: begin
                  if (tick_edge) begin
                     ref_q <= step_d;
                     // Reaching zero returns to IDLE; a reversal passes through zero in RAMP.
                     if (step_d == tgt_d) state_q <= (tgt_d != 16'sd0) ? HOLD : IDLE;
                  end
               end
               HOLD: begin
                  if (tick_edge && tgt_d != ref_q) begin
                     state_q <= RAMP;
                     ref_q   <= step_d;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ref_out   = ref_q;
   assign tick      = tick_q;
   assign state_out = state_q;
   assign settled   = (state_q == IDLE) || (state_q == HOLD);

endmodule

// File: tb/tb_ref_ramp_sequencer.sv
// Directed bench for ref_ramp_sequencer: two instances (STEP 50 and STEP 300) share stimulus;
// expected ref values are queued when stimulus is applied and popped on each tick.
module tb_ref_ramp_sequencer;

   localparam int SD = 4;

   // Handshake-free block: inputs are levels sampled on rising edges; outputs are
   // sampled on falling edges, and ref_out is valid in the cycle tick is high.
   logic               clk;
   logic               rst;
   logic [2:0]         action_in;
   logic               estop;
   logic               fault_clr;
   logic signed [15:0] ref_out,   ref2;
   logic               tick,      tick2;
   logic               settled,   settled2;
   logic [1:0]         state_out, state2;

   logic [15:0] exp_q[$];
   int n_chk  = 0;
   int n_pass = 0;

   ref_ramp_sequencer #(.SAMPLE_DIV(SD), .STEP(50)) dut (
      .clk(clk), .rst(rst), .action_in(action_in), .estop(estop), .fault_clr(fault_clr),
      .ref_out(ref_out), .tick(tick), .settled(settled), .state_out(state_out)
   );

   ref_ramp_sequencer #(.SAMPLE_DIV(SD), .STEP(300)) dut2 (
      .clk(clk), .rst(rst), .action_in(action_in), .estop(estop), .fault_clr(fault_clr),
      .ref_out(ref2), .tick(tick2), .settled(settled2), .state_out(state2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
   endtask

   // Waits for the next tick (sampled on falling edges); returns cycles waited, 0 on timeout.
   task automatic wait_tick(output int cycles);
      cycles = 0;
      for (int i = 1; i <= 4 * SD; i++) begin
         @(negedge clk);
         if (tick) begin
            cycles = i;
            break;
         end
      end
      if (cycles == 0) begin
         n_chk++;
         $error("FAIL tick_timeout observed=none expected=tick within %0d cycles", 4 * SD);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         n_chk++;
         $error("FAIL %s observed=%0d expected=queued value (queue empty)", tag, ref_out);
      end else begin
         e = exp_q.pop_front();
         chk(tag, ref_out, e);
      end
   endtask

   // Counts rising edges after release until tick is seen.
   task automatic first_tick_latency(input string tag);
      int lat;
      lat = 0;
      for (int i = 1; i <= 4 * SD; i++) begin
         @(posedge clk);
         #1;
         if (tick) begin
            lat = i;
            break;
         end
      end
      chk(tag, 16'(lat), 16'(SD));
   endtask

   initial begin
      int cyc;
      rst = 1'b1; action_in = 3'b000; estop = 1'b0; fault_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ref", ref_out, 16'd0);
      chk("rst_state", 16'(state_out), 16'd0);
      chk("rst_tick", 16'(tick), 16'd0);
      chk("rst_settled", 16'(settled), 16'd1);
      rst = 1'b0;
      first_tick_latency("first_tick");

      // Action glitch between ticks while IDLE
      @(negedge clk);
      action_in = 3'b001;
      @(negedge clk);
      @(negedge clk);
      action_in = 3'b000;
      wait_tick(cyc);
      chk("glitch_ref", ref_out, 16'd0);
      chk("glitch_state", 16'(state_out), 16'd0);

      // WALK ramp: 50..1000 in 20 ticks; STEP=300 instance 300,600,900,1000
      action_in = 3'b001;
      for (int k = 1; k <= 20; k++) exp_q.push_back(16'(50 * k));
      for (int k = 1; k <= 20; k++) begin
         wait_tick(cyc);
         chk("walk_spacing", 16'(cyc), 16'(SD));
         pop_chk("walk_ref");
         chk("walk_state", 16'(state_out), (k < 20) ? 16'd1 : 16'd2);
         if (k <= 4) chk("partial_ref", ref2, (k < 4) ? 16'(300 * k) : 16'd1000);
         if (k == 4) chk("partial_state", 16'(state2), 16'd2);
      end
      chk("walk_settled", 16'(settled), 16'd1);

      // Reversal 1000 -> -500 through zero without IDLE
      action_in = 3'b010;
      for (int k = 1; k <= 30; k++) exp_q.push_back(16'(1000 - 50 * k));
      for (int k = 1; k <= 30; k++) begin
         wait_tick(cyc);
         pop_chk("rev_ref");
         if (k == 20) chk("rev_zero_state", 16'(state_out), 16'd1);
      end
      chk("rev_state", 16'(state_out), 16'd2);
      chk("rev_ref2", ref2, -16'sd500);

      // STOP: -500 -> 0 in 10 ticks then IDLE
      action_in = 3'b000;
      for (int k = 1; k <= 10; k++) exp_q.push_back(16'(-500 + 50 * k));
      for (int k = 1; k <= 10; k++) begin
         wait_tick(cyc);
         pop_chk("stop_ref");
         chk("stop_state", 16'(state_out), (k < 10) ? 16'd1 : 16'd0);
      end
      chk("stop_settled", 16'(settled), 16'd1);

      // Estop at 600
      action_in = 3'b001;
      for (int k = 1; k <= 12; k++) exp_q.push_back(16'(50 * k));
      for (int k = 1; k <= 12; k++) begin
         wait_tick(cyc);
         pop_chk("pre_estop_ref");
      end
      estop = 1'b1;
      @(posedge clk);
      #1;
      chk("estop_ref", ref_out, 16'd0);
      chk("estop_state", 16'(state_out), 16'd3);
      chk("estop_settled", 16'(settled), 16'd0);
      @(negedge clk);
      fault_clr = 1'b1;
      repeat (SD + 1) @(negedge clk);
      chk("both_state", 16'(state_out), 16'd3);
      chk("both_ref", ref_out, 16'd0);
      estop = 1'b0;
      @(posedge clk);
      #1;
      chk("clear_state", 16'(state_out), 16'd0);
      @(negedge clk);
      fault_clr = 1'b0;
      exp_q.push_back(16'd50);
      wait_tick(cyc);
      pop_chk("restart_ref");
      chk("restart_state", 16'(state_out), 16'd1);

      // Ramp to 350, then asynchronous reset mid-ramp
      for (int k = 2; k <= 7; k++) exp_q.push_back(16'(50 * k));
      for (int k = 2; k <= 7; k++) begin
         wait_tick(cyc);
         pop_chk("pre_rst_ref");
      end
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ref", ref_out, 16'd0);
      chk("async_rst_state", 16'(state_out), 16'd0);
      chk("async_rst_tick", 16'(tick), 16'd0);
      chk("async_rst_settled", 16'(settled), 16'd1);
      @(negedge clk);
      rst = 1'b0;
      first_tick_latency("rst_first_tick");
      chk("post_rst_ref", ref_out, 16'd50);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
